// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding, default widths
// and the address bit that picks between the two slaves.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam int DEF_ADDR_W         = 7;
   localparam int DEF_DATA_W         = 8;
   localparam int DEF_TIMEOUT_CYCLES = 16;
   localparam int DEF_SEL_BIT        = DEF_ADDR_W - 1;

   // The address MSB selects slave 2; the remaining bits address the slave's word.
   function automatic int sel_bit(input int addr_w);
      return addr_w - 1;
   endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts consecutive ACCESS wait cycles; expired rises combinationally on the
// TIMEOUT_CYCLES-th enabled cycle so the FSM can leave ACCESS on that edge.
module apb_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic PCLK,
   input  logic PRESET,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester for two slaves: valid/ready request in, one rsp_valid pulse per transfer.
// Optional ACCESS timeout is built in when APB_TIMEOUT_EN is defined.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSELECT1,
   output logic              PSELECT2,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA1,
   input  logic [DATA_W-1:0] PRDATA2,
   input  logic              PREADY1,
   input  logic              PREADY2,
   input  logic              PSLVERR1,
   input  logic              PSLVERR2
);

   localparam int SEL_IDX = sel_bit(ADDR_W);

   apb_state_t        state;
   logic              sel_ready;
   logic              sel_err;
   logic [DATA_W-1:0] sel_rdata;
   logic              timeout;

   // PSELECT2 is a registered copy of the decoded address bit, so it steers the mux.
   assign sel_ready = PSELECT2 ? PREADY2  : PREADY1;
   assign sel_err   = PSELECT2 ? PSLVERR2 : PSLVERR1;
   assign sel_rdata = PSELECT2 ? PRDATA2  : PRDATA1;

`ifdef APB_TIMEOUT_EN
   apb_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .clear   (state == SETUP),
      .enable  ((state == ACCESS) && !sel_ready),
      .expired (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         PSELECT1  <= 1'b0;
         PSELECT2  <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  state     <= SETUP;
                  req_ready <= 1'b0;
                  PWRITE    <= req_write;
                  PADDR     <= req_addr;
                  PWDATA    <= req_wdata;
                  PSELECT1  <= !req_addr[SEL_IDX];
                  PSELECT2  <= req_addr[SEL_IDX];
               end
            end
            SETUP: begin
               state   <= ACCESS;
               PENABLE <= 1'b1;
            end
            ACCESS: begin
               // Wait states hold every APB output; only completion or timeout moves on.
               if (sel_ready || timeout) begin
                  state     <= IDLE;
                  PSELECT1  <= 1'b0;
                  PSELECT2  <= 1'b0;
                  PENABLE   <= 1'b0;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_err   <= sel_ready ? sel_err : 1'b1;
                  if (sel_ready && !PWRITE) begin
                     rsp_rdata <= sel_rdata;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               PSELECT1  <= 1'b0;
               PSELECT2  <= 1'b0;
               PENABLE   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: inputs driven and outputs sampled on the falling edge.
// The timeout scenario is included when APB_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       req_valid, req_ready, req_write;
   logic [6:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid, rsp_err;
   logic [7:0] rsp_rdata;
   logic       PSELECT1, PSELECT2, PENABLE, PWRITE;
   logic [6:0] PADDR;
   logic [7:0] PWDATA, PRDATA1, PRDATA2;
   logic       PREADY1, PREADY2, PSLVERR1, PSLVERR2;

   int errors = 0;
   int checks = 0;

   always #5 PCLK = ~PCLK;

   apb_master_bridge dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSELECT1  (PSELECT1),
      .PSELECT2  (PSELECT2),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA1   (PRDATA1),
      .PRDATA2   (PRDATA2),
      .PREADY1   (PREADY1),
      .PREADY2   (PREADY2),
      .PSLVERR1  (PSLVERR1),
      .PSLVERR2  (PSLVERR2)
   );

   // Called at a falling edge (cycle N); returns at the falling edge of cycle N+1 (SETUP).
   task automatic send_req(input logic w, input logic [6:0] a, input logic [7:0] d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      @(negedge PCLK);
      req_valid = 1'b0;
   endtask

   // Steps falling edges until rsp_valid; cycles = edges stepped, -1 if budget ran out.
   task automatic wait_rsp(input int budget, output int cycles);
      cycles = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge PCLK);
         if (rsp_valid === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      PRESET = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK);
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err, PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA}
          !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00}) begin
         errors++;
         $display("FAIL reset_values: ready=%b rv=%b rd=%h err=%b sel=%b%b en=%b wr=%b addr=%h wd=%h, want ready=1 rest 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err, PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA);
      end
      PRESET = 1'b1;
      @(negedge PCLK);
   endtask

   task automatic test_write_slave1();
      int cyc;
      PREADY1 = 1'b1; PREADY2 = 1'b0; PSLVERR1 = 1'b0; PSLVERR2 = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL wr1_ready_idle: got %b want 1", req_ready);
      end
      send_req(1'b1, 7'h05, 8'hA5);
      checks++;
      if ({PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA, req_ready} !== {1'b1, 1'b0, 1'b0, 1'b1, 7'h05, 8'hA5, 1'b0}) begin
         errors++;
         $display("FAIL wr1_setup: sel=%b%b en=%b wr=%b addr=%h wd=%h ready=%b want 1 0 0 1 05 a5 0",
                  PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA, req_ready);
      end
      @(negedge PCLK);
      checks++;
      if ({PSELECT1, PENABLE, rsp_valid} !== 3'b110) begin
         errors++; $display("FAIL wr1_access: sel1=%b en=%b rv=%b want 1 1 0", PSELECT1, PENABLE, rsp_valid);
      end
      wait_rsp(10, cyc);
      checks++;
      if (cyc !== 1 || rsp_err !== 1'b0 || PSELECT1 !== 1'b0 || PENABLE !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr1_rsp: cycles=%0d err=%b sel1=%b en=%b ready=%b want 1 0 0 0 1", cyc, rsp_err, PSELECT1, PENABLE, req_ready);
      end
      @(negedge PCLK);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL wr1_rsp_pulse: rsp_valid=%b want 0", rsp_valid);
      end
      PSLVERR2 = 1'b0; PREADY2 = 1'b1;
   endtask

   task automatic test_read_slave1();
      int cyc;
      logic sel2_seen;
      PRDATA1 = 8'hA5; PRDATA2 = 8'hFF;
      send_req(1'b0, 7'h05, 8'h00);
      sel2_seen = PSELECT2;
      cyc = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge PCLK);
         sel2_seen = sel2_seen | PSELECT2;
         if (rsp_valid === 1'b1) begin
            cyc = i;
            break;
         end
      end
      checks++;
      if (cyc !== 2 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL rd1_rsp: cycles=%0d rdata=%h err=%b want 2 a5 0", cyc, rsp_rdata, rsp_err);
      end
      checks++;
      if (sel2_seen !== 1'b0) begin
         errors++; $display("FAIL rd1_no_sel2: PSELECT2 seen=%b want 0", sel2_seen);
      end
   endtask

   task automatic test_slave2();
      int cyc;
      PRDATA2 = 8'h3C; PRDATA1 = 8'h11;
      send_req(1'b1, 7'h45, 8'h3C);
      checks++;
      if ({PSELECT1, PSELECT2, PADDR, PWDATA} !== {1'b0, 1'b1, 7'h45, 8'h3C}) begin
         errors++; $display("FAIL wr2_setup: sel=%b%b addr=%h wd=%h want 0 1 45 3c", PSELECT1, PSELECT2, PADDR, PWDATA);
      end
      wait_rsp(10, cyc);
      checks++;
      if (cyc !== 2 || rsp_rdata !== 8'hA5) begin
         errors++; $display("FAIL wr2_rdata_hold: cycles=%0d rdata=%h want 2 a5", cyc, rsp_rdata);
      end
      @(negedge PCLK);
      send_req(1'b0, 7'h45, 8'h00);
      checks++;
      if ({PSELECT1, PSELECT2, PWRITE} !== 3'b010) begin
         errors++; $display("FAIL rd2_setup: sel=%b%b wr=%b want 0 1 0", PSELECT1, PSELECT2, PWRITE);
      end
      wait_rsp(10, cyc);
      checks++;
      if (cyc !== 2 || rsp_rdata !== 8'h3C) begin
         errors++; $display("FAIL rd2_rsp: cycles=%0d rdata=%h want 2 3c", cyc, rsp_rdata);
      end
   endtask

   task automatic test_wait_states();
      int cyc;
      logic stable;
      @(negedge PCLK);
      PREADY2 = 1'b0; PREADY1 = 1'b1;
      send_req(1'b1, 7'h46, 8'h77);
      stable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge PCLK);
         if ({PSELECT2, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, req_ready} !== {1'b1, 1'b1, 1'b1, 7'h46, 8'h77, 1'b0, 1'b0})
            stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) begin
         errors++; $display("FAIL wait_stable: outputs changed during wait states, got 0 want 1");
      end
      PREADY2 = 1'b1;
      wait_rsp(10, cyc);
      checks++;
      if (cyc !== 1 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL wait_rsp: cycles after ready=%0d err=%b want 1 0", cyc, rsp_err);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      logic rv_seen;
      @(negedge PCLK);
      PREADY1 = 1'b0;
      send_req(1'b1, 7'h05, 8'h99);
      @(negedge PCLK);
      checks++;
      if (PENABLE !== 1'b1) begin
         errors++; $display("FAIL rst_mid_access: PENABLE=%b want 1", PENABLE);
      end
      PRESET = 1'b0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err, PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA}
          !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00}) begin
         errors++;
         $display("FAIL rst_mid_clear: ready=%b rv=%b rd=%h sel=%b%b en=%b addr=%h wd=%h want 1 0 00 00 0 00 00",
                  req_ready, rsp_valid, rsp_rdata, PSELECT1, PSELECT2, PENABLE, PADDR, PWDATA);
      end
      @(negedge PCLK);
      PRESET = 1'b1; PREADY1 = 1'b1;
      rv_seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge PCLK);
         rv_seen = rv_seen | rsp_valid;
      end
      checks++;
      if (rv_seen !== 1'b0) begin
         errors++; $display("FAIL rst_mid_no_rsp: rsp_valid seen=%b want 0", rv_seen);
      end
      PRDATA1 = 8'h5A;
      send_req(1'b0, 7'h05, 8'h00);
      wait_rsp(10, cyc);
      checks++;
      if (cyc !== 2 || rsp_rdata !== 8'h5A) begin
         errors++; $display("FAIL rst_mid_next: cycles=%0d rdata=%h want 2 5a", cyc, rsp_rdata);
      end
   endtask

   task automatic test_slverr();
      int cyc;
      @(negedge PCLK);
      PSLVERR1 = 1'b1; PRDATA1 = 8'h33;
      send_req(1'b0, 7'h05, 8'h00);
      wait_rsp(10, cyc);
      checks++;
      if (cyc !== 2 || rsp_err !== 1'b1 || rsp_rdata !== 8'h33) begin
         errors++; $display("FAIL slverr: cycles=%0d err=%b rdata=%h want 2 1 33", cyc, rsp_err, rsp_rdata);
      end
      PSLVERR1 = 1'b0;
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout();
      int cyc;
      @(negedge PCLK);
      PREADY1 = 1'b0;
      send_req(1'b1, 7'h07, 8'hEE);
      wait_rsp(40, cyc);
      checks++;
      if (cyc !== 17 || rsp_err !== 1'b1 || rsp_rdata !== 8'h33) begin
         errors++; $display("FAIL timeout_rsp: cycles=%0d err=%b rdata=%h want 17 1 33", cyc, rsp_err, rsp_rdata);
      end
      checks++;
      if ({req_ready, PSELECT1, PENABLE} !== 3'b100) begin
         errors++; $display("FAIL timeout_idle: ready=%b sel1=%b en=%b want 1 0 0", req_ready, PSELECT1, PENABLE);
      end
      PREADY1 = 1'b1;
   endtask
`endif

   initial begin
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      PRDATA1 = '0; PRDATA2 = '0; PREADY1 = 1'b1; PREADY2 = 1'b1;
      PSLVERR1 = 1'b0; PSLVERR2 = 1'b0;
      test_reset();
      test_write_slave1();
      test_read_slave1();
      test_slave2();
      test_wait_states();
      test_reset_mid();
      test_slverr();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
